wptr_full_gen: RTL and testbench



---
 rtl/wptr_full_gen.sv | 128 ++++++++++++
 tb/tb_wptr_full_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_gen.sv
// Write-domain control stage of the asynchronous FIFO.
// Keeps the binary and Gray write pointers, synchronises the read-domain Gray pointer
// into w_clk, and produces a registered full flag for the dual-clock RAM write port.
// Optional feature: define W_ALMOST_FULL_EN to add the registered almost_full output
// (Gray-to-binary conversion of the synchronised read pointer plus an occupancy compare).
module wptr_full_gen #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned PTR_WIDTH   = $clog2(DEPTH),
   parameter int unsigned SYNC_STAGES = 2
`ifdef W_ALMOST_FULL_EN
   ,
   parameter int unsigned AF_THRESH   = DEPTH - 2
`endif
) (
   input  logic                 w_clk,
   input  logic                 w_rst_n,
   input  logic                 w_en,
   input  logic [PTR_WIDTH:0]   r_gray_ptr,
   output logic [PTR_WIDTH-1:0] w_ptr,
   output logic [PTR_WIDTH:0]   w_gray_ptr,
   output logic                 full,
   output logic                 w_accept
`ifdef W_ALMOST_FULL_EN
   ,
   output logic                 almost_full
`endif
);

   // Pointer state: one extra wrap bit distinguishes full from empty.
   logic [PTR_WIDTH:0] w_bin_q;
   logic [PTR_WIDTH:0] w_bin_next;
   logic [PTR_WIDTH:0] w_gray_q;
   logic [PTR_WIDTH:0] w_gray_next;
   logic               full_q;
   logic               full_d;

   // Read-pointer synchroniser chain; rq_gray is the last stage.
   logic [PTR_WIDTH:0] sync_q [SYNC_STAGES];
   logic [PTR_WIDTH:0] rq_gray;
   logic [PTR_WIDTH:0] full_target;

   assign rq_gray = sync_q[SYNC_STAGES-1];

   // A write is performed only when requested and the FIFO is not full.
   assign w_accept = w_en && !full_q;

   // Next binary and Gray pointer values for the coming edge.
   always_comb begin
      w_bin_next  = w_bin_q + {{PTR_WIDTH{1'b0}}, w_accept};
      w_gray_next = w_bin_next ^ (w_bin_next >> 1);
   end

   // Full when the write pointer is exactly DEPTH ahead of the read pointer: in Gray code that
   // is the read pointer with its two MSBs inverted and the remaining bits equal.
   always_comb begin
      full_target = {~rq_gray[PTR_WIDTH:PTR_WIDTH-1], rq_gray[PTR_WIDTH-2:0]};
      full_d      = (w_gray_next == full_target);
   end

   // Pointer and full registers; async clear so outputs drop without waiting for an edge.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         w_bin_q  <= '0;
         w_gray_q <= '0;
         full_q   <= 1'b0;
      end else begin
         w_bin_q  <= w_bin_next;
         w_gray_q <= w_gray_next;
         full_q   <= full_d;
      end
   end

   // Plain flop chain for the asynchronous read pointer; no logic between stages.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= r_gray_ptr;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign w_ptr      = w_bin_q[PTR_WIDTH-1:0];
   assign w_gray_ptr = w_gray_q;
   assign full       = full_q;

`ifdef W_ALMOST_FULL_EN
   localparam logic [PTR_WIDTH:0] AfThreshW = (PTR_WIDTH+1)'(AF_THRESH);

   logic [PTR_WIDTH:0] rq_bin;
   logic [PTR_WIDTH:0] occupancy;
   logic               almost_full_q;
   logic               almost_full_d;

   // Gray-to-binary of the synchronised read pointer, then occupancy mod 2*DEPTH.
   always_comb begin
      rq_bin[PTR_WIDTH] = rq_gray[PTR_WIDTH];
      for (int i = int'(PTR_WIDTH) - 1; i >= 0; i--) begin
         rq_bin[i] = rq_bin[i+1] ^ rq_gray[i];
      end
      occupancy     = w_bin_next - rq_bin;
      almost_full_d = (occupancy >= AfThreshW);
   end

   // Registered almost_full; stale rq_gray makes it pessimistic just like full.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         almost_full_q <= 1'b0;
      end else begin
         almost_full_q <= almost_full_d;
      end
   end

   assign almost_full = almost_full_q;
`endif

   // Design invariants: no write into a full FIFO, and the pointer moves only on a write.
   a_no_write_when_full : assert property (
      @(posedge w_clk) disable iff (!w_rst_n) full_q |-> !w_accept);

   a_ptr_holds : assert property (
      @(posedge w_clk) disable iff (!w_rst_n) !w_accept |=> $stable(w_bin_q));

endmodule

// File: tb/tb_wptr_full_gen.sv
// Directed self-checking bench for wptr_full_gen (DEPTH=8, SYNC_STAGES=2).
// Build with W_ALMOST_FULL_EN defined to also check almost_full (default AF_THRESH=6).
module tb_wptr_full_gen;

   localparam int unsigned Depth    = 8;
   localparam int unsigned PtrWidth = 3;

   logic                w_clk;
   logic                w_rst_n;
   logic                w_en;
   logic [PtrWidth:0]   r_gray_ptr;
   logic [PtrWidth-1:0] w_ptr;
   logic [PtrWidth:0]   w_gray_ptr;
   logic                full;
   logic                w_accept;
`ifdef W_ALMOST_FULL_EN
   logic                almost_full;
`endif

   int n_cmp;
   int n_err;

   wptr_full_gen #(
      .DEPTH       (Depth),
      .PTR_WIDTH   (PtrWidth),
      .SYNC_STAGES (2)
   ) dut (
      .w_clk       (w_clk),
      .w_rst_n     (w_rst_n),
      .w_en        (w_en),
      .r_gray_ptr  (r_gray_ptr),
      .w_ptr       (w_ptr),
      .w_gray_ptr  (w_gray_ptr),
      .full        (full),
      .w_accept    (w_accept)
`ifdef W_ALMOST_FULL_EN
      ,
      .almost_full (almost_full)
`endif
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   function automatic logic [PtrWidth:0] to_gray(input logic [PtrWidth:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check_af(input string tag, input logic exp);
`ifdef W_ALMOST_FULL_EN
      check_eq(tag, 32'(almost_full), 32'(exp));
`endif
   endtask

   logic [PtrWidth:0] wb;
   logic [PtrWidth:0] rd;
   logic [PtrWidth:0] prev_gray;

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      w_rst_n    = 1'b0;
      w_en       = 1'b1;
      r_gray_ptr = '0;

      // Reset held with w_en high: nothing may move.
      repeat (3) tick();
      check_eq("rst_w_ptr", 32'(w_ptr), 32'd0);
      check_eq("rst_w_gray", 32'(w_gray_ptr), 32'd0);
      check_eq("rst_full", 32'(full), 32'd0);
      check_af("rst_af", 1'b0);

      w_en    = 1'b0;
      w_rst_n = 1'b1;
      tick();
      check_eq("post_rst_w_ptr", 32'(w_ptr), 32'd0);

      // Fill: eight writes against an idle reader.
      w_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check_eq($sformatf("fill_ptr_%0d", i), 32'(w_ptr), 32'(i));
         check_eq($sformatf("fill_acc_%0d", i), 32'(w_accept), 32'd1);
         check_eq($sformatf("fill_full_%0d", i), 32'(full), 32'd0);
         check_af($sformatf("fill_af_%0d", i), i >= 6);
         tick();
      end
      check_eq("full_w_ptr", 32'(w_ptr), 32'd0);
      check_eq("full_w_gray", 32'(w_gray_ptr), 32'hc);
      check_eq("full_set", 32'(full), 32'd1);
      check_eq("full_acc", 32'(w_accept), 32'd0);
      check_af("full_af", 1'b1);

      // Writes while full are refused and nothing moves.
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("wf_acc_%0d", i), 32'(w_accept), 32'd0);
         check_eq($sformatf("wf_ptr_%0d", i), 32'(w_ptr), 32'd0);
         check_eq($sformatf("wf_gray_%0d", i), 32'(w_gray_ptr), 32'hc);
         check_eq($sformatf("wf_full_%0d", i), 32'(full), 32'd1);
      end

      // One read: full must survive the first edge, then clear by the third.
      w_en       = 1'b0;
      r_gray_ptr = 4'b0001;
      tick();
      check_eq("deassert_hold", 32'(full), 32'd1);
      tick();
      tick();
      check_eq("deassert_clear", 32'(full), 32'd0);
      w_en = 1'b1;
      #1;
      check_eq("refill_acc", 32'(w_accept), 32'd1);
      tick();
      w_en = 1'b0;
      check_eq("refill_ptr", 32'(w_ptr), 32'd1);
      check_eq("refill_full", 32'(full), 32'd1);
      check_af("refill_af", 1'b1);

      // Drain the reader up to the writer (bin 9), one Gray bit per step.
      rd = 4'd1;
      for (int i = 0; i < 8; i++) begin
         rd         = rd + 4'd1;
         r_gray_ptr = to_gray(rd);
         tick();
      end
      repeat (3) tick();
      check_eq("drain_full", 32'(full), 32'd0);
      check_af("drain_af", 1'b0);

      // Wrap: 20 writes from bin 9 with the reader following; no false full at 15 -> 0.
      wb        = 4'd9;
      prev_gray = to_gray(wb);
      for (int i = 0; i < 20; i++) begin
         w_en = 1'b1;
         #1;
         check_eq($sformatf("wrap_acc_%0d", i), 32'(w_accept), 32'd1);
         tick();
         wb = wb + 4'd1;
         check_eq($sformatf("wrap_ptr_%0d", i), 32'(w_ptr), 32'(wb[PtrWidth-1:0]));
         check_eq($sformatf("wrap_gray_%0d", i), 32'(w_gray_ptr), 32'(to_gray(wb)));
         check_eq($sformatf("wrap_1bit_%0d", i), 32'($countones(w_gray_ptr ^ prev_gray)), 32'd1);
         check_eq($sformatf("wrap_full_%0d", i), 32'(full), 32'd0);
         prev_gray  = w_gray_ptr;
         rd         = rd + 4'd1;
         r_gray_ptr = to_gray(rd);
      end
      check_af("wrap_af", 1'b0);

      // Asynchronous reset between edges in the middle of a burst.
      w_en = 1'b1;
      tick();
      tick();
      check_eq("burst_ptr", 32'(w_ptr), 32'(3'(wb[PtrWidth-1:0] + 3'd2)));
      #3;
      w_rst_n    = 1'b0;
      r_gray_ptr = '0;
      #1;
      check_eq("arst_ptr", 32'(w_ptr), 32'd0);
      check_eq("arst_gray", 32'(w_gray_ptr), 32'd0);
      check_eq("arst_full", 32'(full), 32'd0);
      check_af("arst_af", 1'b0);
      tick();
      check_eq("arst_hold_ptr", 32'(w_ptr), 32'd0);
      w_rst_n = 1'b1;
      tick();
      w_en = 1'b0;
      check_eq("post_arst_ptr", 32'(w_ptr), 32'd1);
      check_eq("post_arst_gray", 32'(w_gray_ptr), 32'd1);
      tick();
      check_eq("post_arst_hold", 32'(w_ptr), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
